// File: rtl/inth_apb_initiator.sv
// ---------------------------------------------------------------------------
// inth_apb_initiator
//
// APB requester for the interrupt-handler/counter core. An accepted start
// writes the latched control word to CTRL_ADDR, then the block waits for irq.
// Each interrupt is serviced by reading NUM_VALUES snapshot registers
// (VALUE_BASE + 4*N), streaming each result on rd_data/rd_index/rd_valid,
// pulsing ack_out, and waiting for irq to drop before pulsing done.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge), async active-low reset
//   start, ctrl_word     host request (IDLE only) and control value
//   abort                level, return to IDLE (WAIT_IRQ only)
//   PSEL..PSLVERR        APB requester bus
//   irq, ack_out         interrupt from / acknowledge to the core
//   rd_data, rd_index,   snapshot value stream, rd_valid one-cycle strobe
//   rd_valid
//   busy, done, err      status: not-IDLE, per-interrupt pulse, sticky error
//
// Optional build macro: INTH_APB_TIMEOUT_EN
//   Adds an 8-bit wait-state counter; an access with PREADY low for 255
//   cycles is terminated with err set (reads deliver 32'hDEAD_BEEF).
// ---------------------------------------------------------------------------
module inth_apb_initiator #(
  parameter logic [31:0] CTRL_ADDR  = 32'h0000_0004,
  parameter logic [31:0] VALUE_BASE = 32'h0000_0010,
  parameter int unsigned NUM_VALUES = 10
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [31:0] ctrl_word,
  input  logic        abort,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        irq,
  output logic        ack_out,
  output logic [31:0] rd_data,
  output logic [3:0]  rd_index,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CFG_SETUP  = 3'd1;
  localparam logic [2:0] S_CFG_ACCESS = 3'd2;
  localparam logic [2:0] S_WAIT_IRQ   = 3'd3;
  localparam logic [2:0] S_RD_SETUP   = 3'd4;
  localparam logic [2:0] S_RD_ACCESS  = 3'd5;
  localparam logic [2:0] S_ACK        = 3'd6;
  localparam logic [2:0] S_WAIT_CLR   = 3'd7;

  localparam logic [3:0]  LAST_IDX     = 4'(NUM_VALUES - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [3:0]  rd_index_q, rd_index_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;

  logic        timeout;
  logic        xfer_end;

  // Bus outputs are decoded from the state register so an asynchronous
  // reset drops PSEL/PENABLE immediately.
  always_comb begin
    PSEL    = (state_q == S_CFG_SETUP) || (state_q == S_CFG_ACCESS) ||
              (state_q == S_RD_SETUP)  || (state_q == S_RD_ACCESS);
    PENABLE = (state_q == S_CFG_ACCESS) || (state_q == S_RD_ACCESS);
    PWRITE  = (state_q == S_CFG_SETUP) || (state_q == S_CFG_ACCESS);
    PADDR   = '0;
    PWDATA  = '0;
    if (PWRITE) begin
      PADDR  = CTRL_ADDR;
      PWDATA = ctrl_q;
    end else if (PSEL) begin
      PADDR = VALUE_BASE + {26'd0, idx_q, 2'b00};
    end
  end

  assign ack_out  = (state_q == S_ACK);
  assign busy     = (state_q != S_IDLE);
  assign rd_data  = rd_data_q;
  assign rd_index = rd_index_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef INTH_APB_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  // wait_q counts PREADY-low access cycles already elapsed; the 255th such
  // cycle ends the transfer.
  assign timeout = PENABLE && !PREADY && (wait_q == 8'd254);
  assign wait_d  = (PENABLE && !PREADY) ? wait_q + 8'd1 : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign xfer_end = PREADY || timeout;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ctrl_d     = ctrl_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ctrl_d  = ctrl_word;
          err_d   = 1'b0;
          state_d = S_CFG_SETUP;
        end
      end
      S_CFG_SETUP: state_d = S_CFG_ACCESS;
      S_CFG_ACCESS: begin
        if (xfer_end) begin
          if ((PREADY && PSLVERR) || timeout) err_d = 1'b1;
          state_d = S_WAIT_IRQ;
        end
      end
      S_WAIT_IRQ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (irq) begin
          idx_d   = '0;
          state_d = S_RD_SETUP;
        end
      end
      S_RD_SETUP: state_d = S_RD_ACCESS;
      S_RD_ACCESS: begin
        if (xfer_end) begin
          rd_data_d  = timeout ? TIMEOUT_DATA : PRDATA;
          rd_index_d = idx_q;
          rd_valid_d = 1'b1;
          if ((PREADY && PSLVERR) || timeout) err_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_ACK;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_RD_SETUP;
          end
        end
      end
      S_ACK: state_d = S_WAIT_CLR;
      S_WAIT_CLR: begin
        if (!irq) begin
          done_d  = 1'b1;
          state_d = S_WAIT_IRQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ctrl_q     <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

endmodule
